// File: rtl/aes_stream_packer.sv
// Packs 32-bit stream words into 128-bit AES blocks behind a DEPTH-entry block buffer; block visible 1 cycle after word 3.
// Backpressure: only word 3 stalls (when the buffer is full); optional byte swap via AES_PACKER_BSWAP_EN.
module aes_stream_packer #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [31:0]                in_data_i,
  input  logic [3:0]                 in_strb_i,
  output logic                       blk_valid_o,
  input  logic                       blk_ready_i,
  output logic [127:0]               blk_data_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic [1:0]                 wcnt_o,
  output logic [CNT_W-1:0]           blocks_cnt_o,
  output logic                       err_strb_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [95:0]      asm_q;
  logic [1:0]       wcnt_q;
  logic [127:0]     mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  logic        full, empty, accept, push, pop;
  logic [31:0] word_in;

`ifdef AES_PACKER_BSWAP_EN
  assign word_in = {in_data_i[7:0], in_data_i[15:8], in_data_i[23:16], in_data_i[31:24]};
`else
  assign word_in = in_data_i;
`endif

  assign full   = (level_q == LW'(DEPTH));
  assign empty  = (level_q == '0);
  // Ready depends only on registered state, never on blk_ready_i.
  assign in_ready_o = (wcnt_q != 2'd3) | ~full;
  assign accept = in_valid_i & in_ready_o;
  assign push   = accept & (wcnt_q == 2'd3);
  assign pop    = ~empty & blk_ready_i;

  assign blk_valid_o  = ~empty;
  assign blk_data_o   = mem_q[rd_ptr_q];
  assign level_o      = level_q;
  assign wcnt_o       = wcnt_q;
  assign blocks_cnt_o = cnt_q;
  assign err_strb_o   = err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      asm_q    <= '0;
      wcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      wcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        case (wcnt_q)
          2'd0:    asm_q[31:0]  <= word_in;
          2'd1:    asm_q[63:32] <= word_in;
          2'd2:    asm_q[95:64] <= word_in;
          default: ;
        endcase
        wcnt_q <= wcnt_q + 2'd1;
        if (in_strb_i != 4'hF) err_q <= 1'b1;
      end
      // Word 3 bypasses the assembly register straight into the tail entry.
      if (push) begin
        mem_q[wr_ptr_q] <= {word_in, asm_q};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        cnt_q    <= cnt_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/aes_stream_packer.md
Name: aes_stream_packer

Overview:
- Upstream neighbour of the AES engine: converts the 32-bit HWPE input stream into complete 128-bit AES blocks.
- Assembles 4 consecutive words into one block and buffers up to DEPTH finished blocks.
- Presents blocks on a valid/ready block port, so the engine core input is loaded in one transfer rather than word-by-word.
- Reports fill level, a block count and a strobe error flag to the control unit.

Parameters:
- DEPTH, 2, number of 128-bit block buffer entries; power of two, >= 2.
- CNT_W, 16, width of blocks_cnt_o.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- clear_i  in  1  synchronous flush, from control.
- in_valid_i  in  1  input stream word valid.
- in_ready_o  out  1  input stream word ready.
- in_data_i  in  32  input stream word.
- in_strb_i  in  4  input byte strobes; must be 4'hF.
- blk_valid_o  out  1  block available.
- blk_ready_i  in  1  consumer accepts block.
- blk_data_o  out  128  head block.
- level_o  out  $clog2(DEPTH)+1  buffered blocks, 0..DEPTH.
- wcnt_o  out  2  words held in the assembly register, 0..3.
- blocks_cnt_o  out  CNT_W  blocks popped since reset/clear.
- err_strb_o  out  1  sticky strobe error.

Behaviour:
- Reset (rst_ni=0 at clk edge):
  - wcnt=0, buffer empty, level_o=0, blk_valid_o=0, blk_data_o=0, blocks_cnt_o=0, err_strb_o=0.
  - in_ready_o=1 after reset.
  - Reset mid-assembly discards partial words.
- Word accept (in_valid_i & in_ready_o):
  - Word k = wcnt goes to assembly bits [32k+31:32k]; word 0 lands in [31:0].
  - wcnt increments and wraps 3->0.
- Block push:
  - Accepting word 3 writes {word3, held[95:0]} into the buffer tail in the same edge; the assembly register is not cleared (it is overwritten).
  - Latency: word 3 accepted at edge n -> blk_valid_o=1 and blk_data_o valid after edge n (visible in cycle n+1).
- in_ready_o = (wcnt != 3) | ~full.
  - Purely a function of registered state; no combinational path from blk_ready_i.
  - Words 0..2 are always accepted, even when the buffer is full.
- Block pop (blk_valid_o & blk_ready_i):
  - Head advances; level decrements; blocks_cnt_o increments, wrapping modulo 2^CNT_W.
  - blk_valid_o = ~empty; blk_data_o is the head entry, stable while blk_valid_o=1 & blk_ready_i=0.
  - When empty, blk_data_o holds its last value (don't care).
- Simultaneous push and pop:
  - Legal at any level except that a push requires ~full, evaluated at the start of the cycle.
  - At level=DEPTH, word 3 is stalled even if a pop occurs in that cycle.
  - Push+pop leaves level unchanged.
- Pointers: log2(DEPTH)-bit read/write pointers wrap naturally; full = (level==DEPTH), empty = (level==0).
- Strobe check: an accepted word with in_strb_i != 4'hF sets err_strb_o (sticky). The word is still accepted and stored as-is.
- clear_i=1:
  - Next state is wcnt=0, buffer empty, blocks_cnt_o=0, err_strb_o=0.
  - Overrides any accept/push/pop in that cycle; in_ready_o is unaffected in that cycle.
  - A word handshaken in the clear cycle is dropped.
- No other state.

Optional Feature:
- Macro: AES_PACKER_BSWAP_EN.
- Defined: each accepted word is byte-reversed before storage, {in[7:0],in[15:8],in[23:16],in[31:24]}, to match the FIPS-197 big-endian byte order. The strobe check uses the original in_strb_i.
- Undefined: words are stored unmodified.
- Latency and handshake are identical in both builds.

Test Plan:
- Words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C back-to-back, blk_ready_i=1 -> one cycle after word 3: blk_valid_o=1, blk_data_o=128'h0F0E0D0C_0B0A0908_07060504_03020100, blocks_cnt_o=1 after pop. With AES_PACKER_BSWAP_EN the expected block is 128'h0C0D0E0F_08090A0B_04050607_00010203.
- blk_ready_i=0, stream 3*4 words with DEPTH=2 -> level_o=2, wcnt_o=3, in_ready_o=0 on the 12th word. Raise blk_ready_i for 1 cycle -> level 1, then word accepted, level 2.
- Push and pop in the same cycle at level 1 -> level_o stays 1; FIFO order preserved across pointer wrap over 5 blocks.
- in_strb_i=4'h7 on word 2 -> err_strb_o=1 next cycle and stays 1; word still stored; block is still emitted.
- clear_i asserted with wcnt=2, level=1, a word handshaking -> next cycle wcnt_o=0, level_o=0, blk_valid_o=0, blocks_cnt_o=0, err_strb_o=0.
- rst_ni=0 for 1 cycle mid-block (wcnt=1) -> all outputs at reset values; next 4 words form a fresh block.
